// File: rtl/temp_sense_pkg.sv
// rtl/temp_sense_pkg.sv - shared types and helpers for the temperature sensor sequencer
// Contents: sequencer state enum, default sensor code width, accumulator width helper.
package temp_sense_pkg;

  localparam int DW_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_CONVERT,
    ST_CAPTURE,
    ST_WAIT
  } ts_state_t;

  // Accumulator must hold 2^avg_log2 full-scale codes without overflow.
  function automatic int acc_width(input int dw, input int avg_log2);
    return dw + avg_log2;
  endfunction

endpackage

// File: rtl/temp_avg_filter.sv
// rtl/temp_avg_filter.sv - box-car average of sensor samples with hysteretic over-temperature alarm
// Ports:
//   clk48, rst_n            clock, synchronous active-low reset
//   sample_stb, sample_data one-cycle sample strobe and its code
//   thr_hi, thr_lo          alarm set / clear thresholds (unsigned)
//   temp_avg, avg_vld       averaged code and its one-cycle update strobe
//   alarm                   over-temperature flag
module temp_avg_filter
  import temp_sense_pkg::*;
#(
  parameter int DW       = DW_DEFAULT,
  parameter int AVG_LOG2 = 2
) (
  input  logic          clk48,
  input  logic          rst_n,
  input  logic          sample_stb,
  input  logic [DW-1:0] sample_data,
  input  logic [DW-1:0] thr_hi,
  input  logic [DW-1:0] thr_lo,
  output logic [DW-1:0] temp_avg,
  output logic          avg_vld,
  output logic          alarm
);

  localparam int AW   = acc_width(DW, AVG_LOG2);
  // Keep the sample counter at least one bit wide; with AVG_LOG2=0 it stays
  // at zero and every sample closes a window.
  localparam int CNTW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'((1 << AVG_LOG2) - 1);

  logic [AW-1:0]   acc;
  logic [AW-1:0]   acc_sum;
  logic [CNTW-1:0] cnt;
  logic [DW-1:0]   avg_new;

  assign acc_sum = acc + AW'(sample_data);
  assign avg_new = DW'(acc_sum >> AVG_LOG2);

  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      temp_avg <= '0;
      avg_vld  <= 1'b0;
      alarm    <= 1'b0;
    end else begin
      avg_vld <= 1'b0;
      if (sample_stb) begin
        if (cnt == CNT_LAST) begin
          acc      <= '0;
          cnt      <= '0;
          temp_avg <= avg_new;
          avg_vld  <= 1'b1;
          // Set wins over clear when the thresholds overlap.
          if (avg_new >= thr_hi) begin
            alarm <= 1'b1;
          end else if (avg_new <= thr_lo) begin
            alarm <= 1'b0;
          end
        end else begin
          acc <= acc_sum;
          cnt <= cnt + CNTW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/temp_sense_ctrl.sv
// rtl/temp_sense_ctrl.sv - on-die temperature diode ADC sequencer (clear, convert, capture, average, alarm)
// Ports:
//   clk48, rst_n          sole clock, synchronous active-low reset
//   enable, start         free-run enable, one-cycle one-shot request
//   thr_hi, thr_lo        alarm set / clear thresholds
//   tsd_clr               clear/start pulse to the sensor
//   tsd_done, tsd_data    sensor conversion done (level) and code
//   temp_raw, sample_vld  last captured code and its one-cycle strobe
//   temp_avg, avg_vld     averaged code and its one-cycle strobe
//   alarm, timeout_err    over-temperature flag, sticky conversion-timeout flag
//   busy                  sequencer not idle
module temp_sense_ctrl
  import temp_sense_pkg::*;
#(
  parameter int DW          = DW_DEFAULT,
  parameter int CLR_CYCLES  = 4,
  parameter int TIMEOUT_CYC = 4096,
  parameter int INTERVAL    = 48000,
  parameter int AVG_LOG2    = 2
) (
  input  logic          clk48,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          start,
  input  logic [DW-1:0] thr_hi,
  input  logic [DW-1:0] thr_lo,
  output logic          tsd_clr,
  input  logic          tsd_done,
  input  logic [DW-1:0] tsd_data,
  output logic [DW-1:0] temp_raw,
  output logic [DW-1:0] temp_avg,
  output logic          sample_vld,
  output logic          avg_vld,
  output logic          alarm,
  output logic          timeout_err,
  output logic          busy
);

  localparam int MAX_A   = (CLR_CYCLES > TIMEOUT_CYC) ? CLR_CYCLES : TIMEOUT_CYC;
  localparam int MAX_CNT = (MAX_A > INTERVAL) ? MAX_A : INTERVAL;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYC - 1);
  // CAPTURE already supplies one idle cycle, so WAIT covers the other
  // INTERVAL-1; the counter reads k-1 on the k-th WAIT cycle.
  localparam logic [CW-1:0] WAIT_LAST = CW'((INTERVAL >= 2) ? INTERVAL - 2 : 0);

  ts_state_t     state;
  ts_state_t     state_nxt;
  logic [CW-1:0] cnt;
  logic          tmo_hit;
  logic          cap_stb;

  always_comb begin
    state_nxt = state;
    tmo_hit   = 1'b0;
    tsd_clr   = 1'b0;
    busy      = 1'b1;
    cap_stb   = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (enable || start) begin
          state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        tsd_clr = 1'b1;
        if (cnt == CLR_LAST) begin
          state_nxt = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        // A done on the last allowed cycle still counts as a good conversion.
        if (tsd_done) begin
          state_nxt = ST_CAPTURE;
        end else if (cnt == TMO_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = ST_CLEAR;
        end
      end
      ST_CAPTURE: begin
        cap_stb   = 1'b1;
        // enable is looked at only here, so a disable during CLEAR/CONVERT
        // lets the conversion in flight finish.
        state_nxt = enable ? ST_WAIT : ST_IDLE;
      end
      ST_WAIT: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
        end else if (cnt == WAIT_LAST) begin
          state_nxt = ST_CLEAR;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      temp_raw    <= '0;
      sample_vld  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      sample_vld <= cap_stb;
      // One shared timer, restarted on every state change.
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (state != ST_IDLE) begin
        cnt <= cnt + CW'(1);
      end
      if (cap_stb) begin
        temp_raw <= tsd_data;
      end
      if (tmo_hit) begin
        timeout_err <= 1'b1;
      end else if (cap_stb) begin
        timeout_err <= 1'b0;
      end
    end
  end

  temp_avg_filter #(
    .DW       (DW),
    .AVG_LOG2 (AVG_LOG2)
  ) u_filter (
    .clk48       (clk48),
    .rst_n       (rst_n),
    .sample_stb  (cap_stb),
    .sample_data (tsd_data),
    .thr_hi      (thr_hi),
    .thr_lo      (thr_lo),
    .temp_avg    (temp_avg),
    .avg_vld     (avg_vld),
    .alarm       (alarm)
  );

endmodule

// File: tb/tb_temp_sense_ctrl.sv
// tb/tb_temp_sense_ctrl.sv - scoreboard bench for temp_sense_ctrl with sensor model and reference average/alarm
module tb_temp_sense_ctrl;

  localparam int DW    = 8;
  localparam int CLR   = 4;
  localparam int TMO   = 300;
  localparam int INTV  = 200;
  localparam int ALOG  = 2;
  localparam int AVG_N = 4;

  logic          clk48 = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] thr_hi = '0;
  logic [DW-1:0] thr_lo = '0;
  logic          tsd_clr;
  logic          tsd_done = 1'b0;
  logic [DW-1:0] tsd_data = '0;
  logic [DW-1:0] temp_raw;
  logic [DW-1:0] temp_avg;
  logic          sample_vld;
  logic          avg_vld;
  logic          alarm;
  logic          timeout_err;
  logic          busy;

  temp_sense_ctrl #(
    .DW(DW), .CLR_CYCLES(CLR), .TIMEOUT_CYC(TMO), .INTERVAL(INTV), .AVG_LOG2(ALOG)
  ) dut (
    .clk48(clk48), .rst_n(rst_n), .enable(enable), .start(start),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .tsd_clr(tsd_clr), .tsd_done(tsd_done),
    .tsd_data(tsd_data), .temp_raw(temp_raw), .temp_avg(temp_avg),
    .sample_vld(sample_vld), .avg_vld(avg_vld), .alarm(alarm),
    .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk48 = ~clk48;

  int cyc = 0;
  always @(posedge clk48) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] raw;
    bit            has_avg;
    logic [DW-1:0] avg;
    bit            alm;
    int            due;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] hist[$];
  logic [DW-1:0] data_q[$];
  logic [DW-1:0] m_avg = '0;
  bit            m_alarm = 1'b0;
  int            rise_q[$];
  int            checks = 0;
  int            failures = 0;
  int            n_samples = 0;
  int            clr_rises = 0;
  bit            sensor_mute = 1'b0;
  bit            rand_delay = 1'b0;
  int            sensor_delay = 20;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk48);
    #1;
  endtask

  // Reference: average is the integer mean of each group of AVG_N samples;
  // alarm follows set/clear/hold from that mean.
  task automatic model_sample(input logic [DW-1:0] d, input int due);
    exp_t e;
    int   sum;
    hist.push_back(d);
    e.raw     = d;
    e.due     = due;
    e.has_avg = 1'b0;
    if (hist.size() == AVG_N) begin
      sum = 0;
      foreach (hist[i]) sum += int'(hist[i]);
      m_avg     = DW'(sum / AVG_N);
      e.has_avg = 1'b1;
      if (m_avg >= thr_hi) m_alarm = 1'b1;
      else if (m_avg <= thr_lo) m_alarm = 1'b0;
      hist.delete();
    end
    e.avg = m_avg;
    e.alm = m_alarm;
    exp_q.push_back(e);
  endtask

  task automatic clear_model();
    exp_q.delete();
    hist.delete();
    data_q.delete();
    rise_q.delete();
    m_avg     = '0;
    m_alarm   = 1'b0;
    n_samples = 0;
    clr_rises = 0;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    start  = 1'b0;
    repeat (3) tick();
    clear_model();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_samples(input int target, input int budget);
    int n = 0;
    while (n_samples < target && n < budget) begin
      tick();
      n++;
    end
    if (n_samples < target) begin
      checks++;
      failures++;
      $display("FAIL wait_samples got=%0d need=%0d", n_samples, target);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check("reach_idle", busy, 0);
  endtask

  // Sensor: answers each conversion after a delay measured from tsd_clr falling.
  initial begin : sensor
    int            d;
    int            hold;
    logic [DW-1:0] v;
    forever begin
      @(negedge tsd_clr);
      if (!sensor_mute && rst_n) begin
        d    = rand_delay ? int'($urandom_range(0, 150)) : sensor_delay;
        hold = rand_delay ? int'($urandom_range(2, 10)) : 2;
        if (data_q.size() > 0) v = data_q.pop_front();
        else v = DW'($urandom_range(8'h30, 8'hD0));
        repeat (d) @(posedge clk48);
        #1;
        tsd_data = v;
        tsd_done = 1'b1;
        model_sample(v, cyc + 2);
        repeat (hold) @(posedge clk48);
        #1;
        tsd_done = 1'b0;
        tsd_data = DW'($urandom);
      end
    end
  end

  // Monitor: pops the scoreboard on every sample_vld.
  initial begin : monitor
    exp_t e;
    int   clr_cnt = 0;
    bit   prev_clr = 1'b0;
    bit   prev_vld = 1'b0;
    forever begin
      @(negedge clk48);
      if (!rst_n) begin
        clr_cnt  = 0;
        prev_clr = 1'b0;
        prev_vld = 1'b0;
      end else begin
        if (tsd_clr) begin
          if (!prev_clr) begin
            clr_rises++;
            rise_q.push_back(cyc);
          end
          clr_cnt++;
        end else if (clr_cnt > 0) begin
          check("clr_width", clr_cnt, CLR);
          clr_cnt = 0;
        end
        prev_clr = tsd_clr;
        if (sample_vld) begin
          n_samples++;
          check("vld_one_cycle", prev_vld, 0);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sample_unexpected actual=0x%0h expected=none", temp_raw);
          end else begin
            e = exp_q.pop_front();
            check("temp_raw", temp_raw, e.raw);
            check("sample_latency", cyc, e.due);
            check("avg_vld", avg_vld, e.has_avg);
            check("temp_avg", temp_avg, e.avg);
            check("alarm", alarm, e.alm);
          end
        end else if (avg_vld) begin
          checks++;
          failures++;
          $display("FAIL avg_without_sample actual=1 expected=0");
        end
        prev_vld = sample_vld;
      end
    end
  end

  initial begin : main
    logic [DW-1:0] exp_avg[5] = '{8'h12, 8'h58, 8'h60, 8'h55, 8'h50};
    bit            exp_alm[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [DW-1:0] grp[4]     = '{8'h58, 8'h60, 8'h55, 8'h50};
    int            fe;
    int            n;
    int            r0;

    // Reset state
    do_reset();
    check("rst_tsd_clr", tsd_clr, 0);
    check("rst_busy", busy, 0);
    check("rst_temp_raw", temp_raw, 0);
    check("rst_temp_avg", temp_avg, 0);
    check("rst_sample_vld", sample_vld, 0);
    check("rst_avg_vld", avg_vld, 0);
    check("rst_alarm", alarm, 0);
    check("rst_timeout_err", timeout_err, 0);

    // One-shot
    thr_hi = 8'hFF;
    thr_lo = 8'h00;
    sensor_delay = 100;
    data_q.push_back(8'h5A);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_samples(1, 500);
    check("oneshot_busy", busy, 0);
    tick();
    check("oneshot_raw", temp_raw, 8'h5A);
    check("oneshot_samples", n_samples, 1);
    check("oneshot_clr_pulses", clr_rises, 1);

    // Averaging and alarm hysteresis in free-run
    do_reset();
    thr_hi = 8'h60;
    thr_lo = 8'h50;
    sensor_delay = 30;
    data_q.push_back(8'h10);
    data_q.push_back(8'h11);
    data_q.push_back(8'h12);
    data_q.push_back(8'h15);
    for (int g = 0; g < 4; g++)
      for (int k = 0; k < 4; k++) data_q.push_back(grp[g]);
    enable = 1'b1;
    for (int g = 0; g < 5; g++) begin
      wait_samples(4 * (g + 1), 2000);
      check("avg_group", temp_avg, exp_avg[g]);
      check("alarm_group", alarm, exp_alm[g]);
    end
    enable = 1'b0;
    wait_idle(10);
    check("freerun_starts", rise_q.size(), 20);
    for (int i = 1; i < rise_q.size(); i++)
      check("freerun_period", rise_q[i] - rise_q[i-1], INTV + CLR + sensor_delay + 1);

    // Timeout, retry, recovery; the failed attempt must not touch the average
    do_reset();
    thr_hi = 8'hFF;
    thr_lo = 8'h00;
    sensor_delay = 20;
    sensor_mute = 1'b1;
    data_q.push_back(8'h20);
    data_q.push_back(8'h22);
    data_q.push_back(8'h24);
    data_q.push_back(8'h26);
    enable = 1'b1;
    n = 0;
    while (!tsd_clr && n < 20) begin tick(); n++; end
    while (tsd_clr && n < 40) begin tick(); n++; end
    fe = cyc;
    n = 0;
    while (!timeout_err && n < TMO + 50) begin tick(); n++; end
    check("timeout_set", timeout_err, 1);
    check("timeout_cycles", cyc - fe, TMO);
    check("timeout_reclear", tsd_clr, 1);
    sensor_mute = 1'b0;
    wait_samples(1, 2000);
    check("timeout_cleared", timeout_err, 0);
    wait_samples(4, 2000);
    enable = 1'b0;
    check("timeout_avg", temp_avg, 8'h23);
    wait_idle(10);

    // Disable during CONVERT
    do_reset();
    sensor_delay = 80;
    enable = 1'b1;
    n = 0;
    while (!tsd_clr && n < 20) begin tick(); n++; end
    while (tsd_clr && n < 40) begin tick(); n++; end
    repeat (10) tick();
    enable = 1'b0;
    wait_samples(1, 500);
    r0 = clr_rises;
    repeat (400) tick();
    check("disable_no_restart", clr_rises, r0);
    check("disable_samples", n_samples, 1);
    check("disable_busy", busy, 0);

    // Randomised free-run with ignored start pulses and overlapping thresholds
    do_reset();
    rand_delay = 1'b1;
    thr_hi = DW'($urandom_range(8'h50, 8'hB0));
    thr_lo = DW'($urandom_range(8'h40, 8'hA0));
    enable = 1'b1;
    n = 0;
    while (n_samples < 12 && n < 8000) begin
      start = ($urandom_range(0, 40) == 0);
      tick();
      n++;
    end
    start = 1'b0;
    check("random_samples", n_samples >= 12, 1);
    enable = 1'b0;
    wait_idle(400);
    repeat (20) tick();
    check("pending_expect", exp_q.size(), 0);

    // Reset during CLEAR; start held during reset must not latch
    sensor_mute = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!tsd_clr && n < 5) begin tick(); n++; end
    check("pre_reset_clr", tsd_clr, 1);
    rst_n = 1'b0;
    start = 1'b1;
    tick();
    check("midrst_tsd_clr", tsd_clr, 0);
    check("midrst_busy", busy, 0);
    check("midrst_temp_raw", temp_raw, 0);
    check("midrst_temp_avg", temp_avg, 0);
    check("midrst_sample_vld", sample_vld, 0);
    check("midrst_avg_vld", avg_vld, 0);
    check("midrst_alarm", alarm, 0);
    check("midrst_timeout_err", timeout_err, 0);
    clear_model();
    rst_n = 1'b1;
    start = 1'b0;
    repeat (5) tick();
    check("postrst_busy", busy, 0);
    check("postrst_clr", clr_rises, 0);
    check("final_pending", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
